// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter: round-robin single-owner arbiter for fetch and data ports.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        ex_mem_ena,
  input  logic        ex_mem_rw,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_wdata,
  output logic        ex_ack,
  output logic [31:0] ex_rdata,
  output logic        bus_req,
  output logic        bus_rw,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic        stall_o
);

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CNT_W = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The counter starts at 0 in the first bus_req cycle, so T cycles end at T-1.
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_FETCH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_fetch;
  logic [CNT_W-1:0] r_cnt;
  logic             w_busy;
  logic             w_timeout;
  logic             w_done;
  logic             w_grant_data;
  logic             w_grant_fetch;

  assign w_busy    = (r_state != S_IDLE);
  assign w_timeout = TMO_EN && w_busy && !bus_ack && (r_cnt >= CNT_LIM);
  assign w_done    = w_busy && (bus_ack || w_timeout);

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_data  = 1'b0;
    w_grant_fetch = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ex_mem_ena && if_req) begin
          w_grant_data  = r_last_fetch;
          w_grant_fetch = !r_last_fetch;
        end else begin
          w_grant_data  = ex_mem_ena;
          w_grant_fetch = if_req;
        end
        if (w_grant_data) begin
          w_state_nxt = S_DATA;
        end else if (w_grant_fetch) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DATA, S_FETCH: begin
        if (w_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_fetch <= 1'b1;
      r_cnt        <= '0;
      bus_req      <= 1'b0;
      bus_rw       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
    end else begin
      if (w_grant_data) begin
        r_last_fetch <= 1'b0;
        r_cnt        <= '0;
        bus_req      <= 1'b1;
        bus_rw       <= ex_mem_rw;
        bus_addr     <= ex_mem_addr;
        bus_wdata    <= ex_mem_wdata;
      end else if (w_grant_fetch) begin
        r_last_fetch <= 1'b1;
        r_cnt        <= '0;
        bus_req      <= 1'b1;
        bus_rw       <= 1'b0;
        bus_addr     <= if_addr;
      end else if (w_done) begin
        bus_req <= 1'b0;
      end
      if (w_busy && !bus_ack && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign ex_ack   = (r_state == S_DATA) && (bus_ack || w_timeout);
  assign if_ack   = (r_state == S_FETCH) && (bus_ack || w_timeout);
  assign ex_rdata = (ex_ack && !w_timeout) ? bus_rdata : '0;
  assign if_rdata = (if_ack && !w_timeout) ? bus_rdata : '0;
  assign bus_err  = w_timeout;
  assign stall_o  = ex_mem_ena && !ex_ack;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

- Single-owner arbiter for the core's one shared memory bus. Two requesters: instruction fetch and the execute stage's data-memory port.
- The execute port carries `mem_ena`/`mem_rw`/`mem_addr`/`mem_data`.
- Runs one transaction at a time with req/ack handshakes, alternates grants round-robin on contention, and aborts hung transactions with a timeout.
- Sits between the pipeline stages and the external memory/bus interface. It also drives the stall request the pipeline controller uses to freeze EX.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles a granted transaction waits for `bus_ack`. 0 disables the timeout.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock.
  - `rst_n`  in  1  asynchronous, active-low reset.
- Fetch port:
  - `if_req`  in  1  fetch request (always a read).
  - `if_addr`  in  32  fetch address.
  - `if_ack`  out  1  fetch completion, one cycle.
  - `if_rdata`  out  32  fetch data, valid when `if_ack`.
- Execute (data) port:
  - `ex_mem_ena`  in  1  data request.
  - `ex_mem_rw`  in  1  0 = read, 1 = write (`MEM_READ`/`MEM_WRITE`).
  - `ex_mem_addr`  in  32  data address.
  - `ex_mem_wdata`  in  32  write data.
  - `ex_ack`  out  1  data completion, one cycle.
  - `ex_rdata`  out  32  read data, valid when `ex_ack`.
- Bus side:
  - `bus_req`  out  1  transaction request.
  - `bus_rw`  out  1  direction.
  - `bus_addr`  out  32  address.
  - `bus_wdata`  out  32  write data.
  - `bus_ack`  in  1  bus completion.
  - `bus_rdata`  in  32  bus read data.
- Status:
  - `bus_err`  out  1  one-cycle pulse with the ack of a timed-out transaction.
  - `stall_o`  out  1  EX stall request.

## Operation

- **FSM states:** IDLE, DATA, FETCH.
- **IDLE:**
  - Only `ex_mem_ena` set → DATA. Only `if_req` set → FETCH.
  - Both set → grant the requester not in `last_grant`, then update `last_grant` to the winner. `last_grant` resets to FETCH, so data wins the first tie.
- **On grant (IDLE exit edge):**
  - Latch the winner's addr/rw/wdata into `bus_addr`/`bus_rw`/`bus_wdata`. Fetch forces `bus_rw` = 0.
  - Set `bus_req` = 1 and clear the timeout counter.
- **DATA/FETCH:**
  - Hold `bus_req` and all bus outputs stable until completion.
  - Completion occurs when `bus_ack` = 1, or when the counter reaches `TIMEOUT_CYCLES` with the timeout enabled.
  - On the completion edge: drop `bus_req` and return to IDLE.
- **Acks (combinational in the completion cycle):**
  - `ex_ack`/`if_ack` = (state matches) & (`bus_ack` | timeout).
  - `ex_rdata`/`if_rdata` = `bus_rdata` on a normal ack, 0 on timeout. They are 0 whenever the port's ack is low.
  - `bus_err` = timeout & completion.
- **Requester rules:**
  - A requester holds its request and operands until it sees its ack.
  - A request dropped mid-transaction is ignored: the transaction completes and the ack is produced.
  - Operand changes after grant have no effect.
- **Stall:** `stall_o` = `ex_mem_ena` & ~`ex_ack` (combinational).
- **Timeout counter:**
  - Width is clog2(`TIMEOUT_CYCLES`+1) bits.
  - Increments each DATA/FETCH cycle in which `bus_ack` is low, and saturates; it never wraps.
  - `bus_ack` arriving in the same cycle the counter hits the limit counts as a normal ack: no `bus_err`, real data.
- **Reset:** asynchronous assertion forces IDLE from any state, mid-transaction included. The aborted transaction produces no ack.

## Timing

- **Reset values:**
  - `bus_req`=0, `bus_rw`=0, `bus_addr`=0, `bus_wdata`=0.
  - State IDLE, `last_grant`=FETCH, counter 0.
  - Combinational outputs with no request present: `if_ack`=0, `ex_ack`=0, rdata 0, `bus_err`=0, `stall_o`=0.
- **Latency:**
  - Request seen in IDLE at cycle N → `bus_req` high at N+1.
  - `bus_ack` at cycle N+k (k≥1) → requester ack in the same cycle N+k, with `bus_req` low at N+k+1.
  - Back-to-back transactions: IDLE occupies one cycle between them. Minimum spacing is 2 cycles per transaction with zero-wait memory (`bus_ack` high in the first `bus_req` cycle).
- **Ignored inputs:** `bus_ack` while `bus_req`=0 is ignored and produces no ack.
- **Timeout length:** with `TIMEOUT_CYCLES`=T, a silent bus completes the transaction in cycle N+T, i.e. T cycles of `bus_req` high.

## Test plan

- Single data write, addr 0x100, wdata 0xDEADBEEF, `bus_ack` after 3 cycles:
  - `bus_req` high cycles N+1..N+3 with rw=1 and stable addr/data.
  - `ex_ack` in cycle N+3 only; `stall_o` high N..N+2, low at N+3.
- Simultaneous `if_req` and `ex_mem_ena` held continuously, zero-wait bus:
  - Grants alternate DATA, FETCH, DATA, FETCH.
  - `if_rdata`/`ex_rdata` equal the `bus_rdata` driven per transaction.
- Fetch read addr 0x40, `bus_rdata` 0x00000013, then `if_addr` changed mid-transaction:
  - `bus_addr` stays 0x40; `if_rdata`=0x00000013 with `if_ack`.
- `TIMEOUT_CYCLES`=4, `bus_ack` never asserted on a data read:
  - `ex_ack` and `bus_err` pulse in the 4th `bus_req` cycle, `ex_rdata`=0.
  - Next request is granted normally.
- `TIMEOUT_CYCLES`=4 with `bus_ack` arriving exactly in the 4th cycle:
  - Normal ack, `bus_err`=0, data passed through.
- `rst_n` pulsed low in the 2nd cycle of a pending fetch:
  - `bus_req` drops asynchronously, no `if_ack`, state IDLE.
  - After release, a simultaneous request pair grants DATA first.
